// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: advances a LED_WIDTH-bit display pattern once per level
// change of the synchronized divider tick, in one of four selectable patterns.
module led_pattern_sequencer #(
    parameter int LED_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iTick,
    input  logic [1:0]           iMode,
    input  logic                 iPause,
    input  logic                 iClear,
    output logic [LED_WIDTH-1:0] oLed,
    output logic                 oStep,
    output logic [2:0]           oState
);

    typedef enum logic [2:0] {
        S_BIN   = 3'd0,
        S_ROT   = 3'd1,
        S_BNC_L = 3'd2,
        S_BNC_R = 3'd3,
        S_FILL  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_ROT  = 2'b01;
    localparam logic [1:0] MODE_BNC  = 2'b10;
    localparam logic [1:0] MODE_FILL = 2'b11;

    localparam logic [LED_WIDTH-1:0] LED_ZERO = '0;
    localparam logic [LED_WIDTH-1:0] LED_ONE  = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0] LED_ONES = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   step;

    state_t                 state_q;
    logic [LED_WIDTH-1:0]   led_q;
    logic                   step_q;
    logic [1:0]             mode_q;

    state_t                 seed_state_d;
    logic [LED_WIDTH-1:0]   seed_led_d;
    state_t                 adv_state_d;
    logic [LED_WIDTH-1:0]   adv_led_d;

    logic [LED_WIDTH-1:0]   led_shl;
    logic [LED_WIDTH-1:0]   led_shr;
    logic [LED_WIDTH-1:0]   led_rol;
    logic [LED_WIDTH-1:0]   led_fill;

    // Tick synchronizer plus one delay flop; any level change becomes a 1-cycle step.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iTick};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign step = sync_q[SYNC_STAGES-1] ^ dly_q;

    always_comb begin
        seed_led_d   = LED_ZERO;
        seed_state_d = S_BIN;
        case (iMode)
            MODE_ROT: begin
                seed_led_d   = LED_ONE;
                seed_state_d = S_ROT;
            end
            MODE_BNC: begin
                seed_led_d   = LED_ONE;
                seed_state_d = S_BNC_L;
            end
            MODE_FILL: begin
                seed_led_d   = LED_ZERO;
                seed_state_d = S_FILL;
            end
            default: begin
                seed_led_d   = LED_ZERO;
                seed_state_d = S_BIN;
            end
        endcase
    end

    assign led_shl  = {led_q[LED_WIDTH-2:0], 1'b0};
    assign led_shr  = {1'b0, led_q[LED_WIDTH-1:1]};
    assign led_rol  = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
    assign led_fill = {led_q[LED_WIDTH-2:0], 1'b1};

    // An empty bus in ROT/BOUNCE would never light again, so it reloads the seed.
    always_comb begin
        adv_led_d   = led_q;
        adv_state_d = state_q;
        case (state_q)
            S_BIN: begin
                adv_led_d = led_q + LED_ONE;
            end
            S_ROT: begin
                adv_led_d = (led_q == LED_ZERO) ? LED_ONE : led_rol;
            end
            S_BNC_L: begin
                if (led_q == LED_ZERO) begin
                    adv_led_d   = LED_ONE;
                    adv_state_d = S_BNC_L;
                end else begin
                    adv_led_d = led_shl;
                    if (led_shl[LED_WIDTH-1]) begin
                        adv_state_d = S_BNC_R;
                    end
                end
            end
            S_BNC_R: begin
                if (led_q == LED_ZERO) begin
                    adv_led_d   = LED_ONE;
                    adv_state_d = S_BNC_L;
                end else begin
                    adv_led_d = led_shr;
                    if (led_shr[0]) begin
                        adv_state_d = S_BNC_L;
                    end
                end
            end
            S_FILL: begin
                adv_led_d = led_fill;
                if (led_fill == LED_ONES) begin
                    adv_state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                adv_led_d = led_shl;
                if (led_shl == LED_ZERO) begin
                    adv_state_d = S_FILL;
                end
            end
            default: begin
                adv_led_d   = LED_ZERO;
                adv_state_d = S_BIN;
            end
        endcase
    end

    // Clear and mode change both reload the seed and swallow a coincident step.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_BIN;
            led_q   <= LED_ZERO;
            step_q  <= 1'b0;
            mode_q  <= MODE_BIN;
        end else begin
            step_q <= 1'b0;
            if (iClear || (iMode != mode_q)) begin
                led_q   <= seed_led_d;
                state_q <= seed_state_d;
                mode_q  <= iMode;
            end else if (!iPause && step) begin
                led_q   <= adv_led_d;
                state_q <= adv_state_d;
                step_q  <= 1'b1;
            end
        end
    end

    assign oLed   = led_q;
    assign oStep  = step_q;
    assign oState = state_q;

endmodule
